axi4lite_slave_regs: RTL and testbench

- AXI4-Lite responder (slave) for the 5-channel, no-strobe interface driven by the team's AXI4-Lite initiator.
- Backs a bank of NUM_REGS 32-bit read/write control registers.
- Register contents are exported as a flat vector to configure NoC blocks (router/NI control).
- One outstanding read and one outstanding write; channels are handled independently.

---
 rtl/axi4lite_pkg.sv | 12 +
 rtl/axi4lite_addr_decode.sv | 31 +++
 rtl/axi4lite_slave_regs.sv | 172 +++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite widths and response codes for the register-slave slice.
package axi4lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_addr_decode.sv
// Combinational byte-address decode into a register index and AXI response code.
module axi4lite_addr_decode
  import axi4lite_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         IDX_W     = $clog2(NUM_REGS)
) (
  input  logic [AXI_ADDR_W-1:0] addr_i,
  output logic [IDX_W-1:0]      index_o,
  output logic [1:0]            resp_o
);

  localparam logic [AXI_ADDR_W-1:0] SPAN = AXI_ADDR_W'(NUM_REGS * 4);

  logic [AXI_ADDR_W-1:0] off;

  assign off     = addr_i - BASE_ADDR;
  assign index_o = off[2 +: IDX_W];

  // Out-of-window addresses take priority over misalignment.
  always_comb begin
    resp_o = RESP_OKAY;
    if ((addr_i < BASE_ADDR) || (off >= SPAN)) begin
      resp_o = RESP_DECERR;
    end else if (addr_i[1:0] != 2'b00) begin
      resp_o = RESP_SLVERR;
    end
  end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register bank slave with independent read and write channels.
// Optional read-only ID register 0 is compiled in with AXI4LITE_SLAVE_ID_REG_EN.
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hA0C1_0001
) (
  input  logic                   aclk,
  input  logic                   arestn,
  input  logic [31:0]            araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [31:0]            awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [NUM_REGS*32-1:0] reg_out
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];

  logic                  rvalid_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [IDX_W-1:0]      rdIdx;
  logic [1:0]            rdResp;
  logic [AXI_DATA_W-1:0] rdWord;

  logic                  awHeld_q, awHeld_d;
  logic [AXI_ADDR_W-1:0] awAddr_q, awAddr_d;
  logic                  wHeld_q, wHeld_d;
  logic [AXI_DATA_W-1:0] wData_q, wData_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [AXI_ADDR_W-1:0] wrAddr;
  logic [AXI_DATA_W-1:0] wrData;
  logic [IDX_W-1:0]      wrIdx;
  logic [1:0]            wrDecResp;
  logic [1:0]            wrResp;
  logic                  awHs, wHs, commit;

  axi4lite_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_rdDecode (
    .addr_i (araddr),
    .index_o(rdIdx),
    .resp_o (rdResp)
  );

  axi4lite_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_wrDecode (
    .addr_i (wrAddr),
    .index_o(wrIdx),
    .resp_o (wrDecResp)
  );

  assign arready = !rvalid_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = !awHeld_q;
  assign wready  = !wHeld_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

`ifdef AXI4LITE_SLAVE_ID_REG_EN
  assign rdWord = (rdIdx == '0) ? ID_VALUE : regs_q[rdIdx];
  assign wrResp = ((wrDecResp == RESP_OKAY) && (wrIdx == '0)) ? RESP_SLVERR : wrDecResp;
`else
  assign rdWord = regs_q[rdIdx];
  assign wrResp = wrDecResp;
`endif

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rdResp;
      rdata_q  <= (rdResp == RESP_OKAY) ? rdWord : '0;
    end else if (rvalid_q && rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // A beat is usable either from its holding stage or straight off the bus this cycle.
  assign awHs   = awvalid && awready;
  assign wHs    = wvalid && wready;
  assign wrAddr = awHeld_q ? awAddr_q : awaddr;
  assign wrData = wHeld_q ? wData_q : wdata;
  assign commit = (awHeld_q || awHs) && (wHeld_q || wHs) && (!bvalid_q || bready);

  always_comb begin
    awHeld_d = awHeld_q;
    awAddr_d = awAddr_q;
    wHeld_d  = wHeld_q;
    wData_d  = wData_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      awHeld_d = 1'b0;
      wHeld_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = wrResp;
    end else begin
      if (bvalid_q && bready) begin
        bvalid_d = 1'b0;
      end
      if (awHs) begin
        awHeld_d = 1'b1;
        awAddr_d = awaddr;
      end
      if (wHs) begin
        wHeld_d = 1'b1;
        wData_d = wdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      awHeld_q <= 1'b0;
      awAddr_q <= '0;
      wHeld_q  <= 1'b0;
      wData_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      awHeld_q <= awHeld_d;
      awAddr_q <= awAddr_d;
      wHeld_q  <= wHeld_d;
      wData_q  <= wData_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit && (wrResp == RESP_OKAY)) begin
      regs_q[wrIdx] <= wrData;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regOut
`ifdef AXI4LITE_SLAVE_ID_REG_EN
    if (g == 0) begin : g_id
      assign reg_out[31:0] = ID_VALUE;
    end else begin : g_rw
      assign reg_out[32*g +: 32] = regs_q[g];
    end
`else
    assign reg_out[32*g +: 32] = regs_q[g];
`endif
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Scoreboard bench for axi4lite_slave_regs; response expectations are queued at issue time
// and popped by a monitor as R/B handshakes occur. Honors AXI4LITE_SLAVE_ID_REG_EN.
module tb_axi4lite_slave_regs;

  localparam int          NUM_REGS = 8;
  localparam logic [31:0] ID_VALUE = 32'hA0C1_0001;

  logic                   aclk = 1'b0;
  logic                   arestn = 1'b0;
  logic [31:0]            araddr = '0;
  logic                   arvalid = 1'b0;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready = 1'b1;
  logic [31:0]            awaddr = '0;
  logic                   awvalid = 1'b0;
  logic                   awready;
  logic [31:0]            wdata = '0;
  logic                   wvalid = 1'b0;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready = 1'b1;
  logic [NUM_REGS*32-1:0] reg_out;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [33:0] rdExpQ[$];
  logic [1:0]  wrExpQ[$];
  logic [33:0] rExp;
  logic [1:0]  bExp;
  logic [31:0] expReg [NUM_REGS];

  axi4lite_slave_regs #(.NUM_REGS(NUM_REGS), .BASE_ADDR(32'h0), .ID_VALUE(ID_VALUE)) dut (
    .aclk(aclk), .arestn(arestn),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .reg_out(reg_out)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation whenever a response handshake is seen.
  always @(negedge aclk) begin
    if (arestn) begin
      if (rvalid && rready) begin
        if (rdExpQ.size() == 0) begin
          checkOutput("rUnexpected", 32'd1, 32'd0);
        end else begin
          rExp = rdExpQ.pop_front();
          checkOutput("rdata", rdata, rExp[31:0]);
          checkOutput("rresp", 32'(rresp), 32'(rExp[33:32]));
        end
      end
      if (bvalid && bready) begin
        if (wrExpQ.size() == 0) begin
          checkOutput("bUnexpected", 32'd1, 32'd0);
        end else begin
          bExp = wrExpQ.pop_front();
          checkOutput("bresp", 32'(bresp), 32'(bExp));
        end
      end
    end
  end

  task automatic sendAw(input logic [31:0] a);
    int n = 0;
    awaddr  = a;
    awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!awready) checkOutput("awTimeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] d);
    int n = 0;
    wdata  = d;
    wvalid = 1'b1;
    @(negedge aclk);
    while (!wready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!wready) checkOutput("wTimeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1 wvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [31:0] a);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!arready) checkOutput("arTimeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
  endtask

  // One transaction with its expected response queued before it is driven.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] expResp, input logic [31:0] expRdata);
    if (isWrite) begin
      wrExpQ.push_back(expResp);
      if (expResp == 2'b00) expReg[addr[4:2]] = data;
      fork
        sendAw(addr);
        sendW(data);
      join
    end else begin
      rdExpQ.push_back({expResp, expRdata});
      sendAr(addr);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rdExpQ.size() != 0 || wrExpQ.size() != 0) && n < 50) begin
      @(posedge aclk);
      n++;
    end
    checkOutput("drainPending", 32'(rdExpQ.size() + wrExpQ.size()), 32'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      checkOutput(tag, reg_out[32*i +: 32], expReg[i]);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NUM_REGS; i++) expReg[i] = '0;
`ifdef AXI4LITE_SLAVE_ID_REG_EN
    expReg[0] = ID_VALUE;
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rstRvalid", 32'(rvalid), 32'd0);
    checkOutput("rstBvalid", 32'(bvalid), 32'd0);
    checkOutput("rstArready", 32'(arready), 32'd1);
    checkOutput("rstAwready", 32'(awready), 32'd1);
    checkOutput("rstWready", 32'(wready), 32'd1);
    checkOutput("rstRdata", rdata, 32'd0);
    checkOutput("rstResp", 32'({rresp, bresp}), 32'd0);
    checkAllRegs("rstRegs");
    @(posedge aclk);
    #1 arestn = 1'b1;
    @(posedge aclk);
    #1;

    // AW and W together: response is visible right after the accepting edge.
    applyStimulus(1'b1, 32'h04, 32'hDEAD_BEEF, 2'b00, 32'h0);
    checkOutput("bLatency", 32'(bvalid), 32'd1);
    drain();
    checkOutput("regOut1", reg_out[63:32], 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h04, 32'h0, 2'b00, 32'hDEAD_BEEF);
    drain();

    // W first, AW three cycles later.
    wrExpQ.push_back(2'b00);
    expReg[2] = 32'h1234;
    sendW(32'h1234);
    checkOutput("wHeldReady", 32'(wready), 32'd0);
    repeat (3) @(posedge aclk);
    #1 checkOutput("wOnlyNoB", 32'(bvalid), 32'd0);
    sendAw(32'h08);
    checkOutput("wFirstCommit", 32'(bvalid), 32'd1);
    drain();

    // AW first, W three cycles later.
    wrExpQ.push_back(2'b00);
    expReg[4] = 32'h5678;
    sendAw(32'h10);
    checkOutput("awHeldReady", 32'(awready), 32'd0);
    repeat (3) @(posedge aclk);
    #1 checkOutput("awOnlyNoB", 32'(bvalid), 32'd0);
    sendW(32'h5678);
    checkOutput("awFirstCommit", 32'(bvalid), 32'd1);
    drain();
    applyStimulus(1'b0, 32'h08, 32'h0, 2'b00, 32'h1234);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b00, 32'h5678);
    drain();

    // Error decodes leave the bank untouched.
    applyStimulus(1'b1, 32'h20, 32'h9999, 2'b11, 32'h0);
    applyStimulus(1'b1, 32'h0E, 32'h7777, 2'b10, 32'h0);
    drain();
    checkAllRegs("errNoWrite");
    applyStimulus(1'b0, 32'h06, 32'h0, 2'b10, 32'h0);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0, 2'b11, 32'h0);
    drain();

    // Stall B with a pending DECERR; the next OKAY write waits in the holding stages.
    bready = 1'b0;
    applyStimulus(1'b1, 32'h40, 32'h1, 2'b11, 32'h0);
    applyStimulus(1'b1, 32'h18, 32'hBBBB, 2'b00, 32'h0);
    checkOutput("stallAwready", 32'(awready), 32'd0);
    checkOutput("stallWready", 32'(wready), 32'd0);
    repeat (5) @(posedge aclk);
    #1;
    checkOutput("stallBvalid", 32'(bvalid), 32'd1);
    checkOutput("stallBresp", 32'(bresp), 32'd3);
    checkOutput("stallNoWrite", reg_out[32*6 +: 32], 32'd0);
    bready = 1'b1;
    drain();
    checkAllRegs("afterStall");

    // Read sampled on the same edge as a write commit sees the old value.
    applyStimulus(1'b1, 32'h0C, 32'h1, 2'b00, 32'h0);
    drain();
    rdExpQ.push_back({2'b00, 32'h1});
    wrExpQ.push_back(2'b00);
    expReg[3] = 32'h2;
    fork
      sendAr(32'h0C);
      sendAw(32'h0C);
      sendW(32'h2);
    join
    drain();
    applyStimulus(1'b0, 32'h0C, 32'h0, 2'b00, 32'h2);
    drain();

`ifdef AXI4LITE_SLAVE_ID_REG_EN
    applyStimulus(1'b0, 32'h00, 32'h0, 2'b00, ID_VALUE);
    applyStimulus(1'b1, 32'h00, 32'h5555, 2'b10, 32'h0);
    drain();
    applyStimulus(1'b0, 32'h00, 32'h0, 2'b00, ID_VALUE);
    drain();
    checkOutput("idRegOut", reg_out[31:0], ID_VALUE);
`else
    applyStimulus(1'b1, 32'h00, 32'hCAFE_F00D, 2'b00, 32'h0);
    drain();
    applyStimulus(1'b0, 32'h00, 32'h0, 2'b00, 32'hCAFE_F00D);
    drain();
    checkOutput("reg0Out", reg_out[31:0], 32'hCAFE_F00D);
`endif

    // Reset with a response pending and an address held: everything is dropped.
    bready = 1'b0;
    applyStimulus(1'b1, 32'h1C, 32'h77, 2'b00, 32'h0);
    sendAw(32'h04);
    checkOutput("preRstAwready", 32'(awready), 32'd0);
    arestn = 1'b0;
    #2;
    rdExpQ.delete();
    wrExpQ.delete();
    clearModel();
    checkOutput("midRstBvalid", 32'(bvalid), 32'd0);
    checkOutput("midRstAwready", 32'(awready), 32'd1);
    checkAllRegs("midRstRegs");
    @(posedge aclk);
    #1 arestn = 1'b1;
    bready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 checkOutput("postRstNoB", 32'(bvalid), 32'd0);
    applyStimulus(1'b0, 32'h1C, 32'h0, 2'b00, 32'h0);
    applyStimulus(1'b0, 32'h04, 32'h0, 2'b00, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
